// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: captures the decoded bundle, detects load-use hazards
// against the instruction in EX, inserts bubbles and counts them (saturating).
module id_ex_stage_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Hold,
  input  logic                      Flush,
  input  logic                      Valid_in,
  input  logic                      RegDst_in,
  input  logic                      MemRead_in,
  input  logic                      MemToReg_in,
  input  logic                      MemWrite_in,
  input  logic                      ALUSrc_in,
  input  logic                      RegWrite_in,
  input  logic [3:0]                ALUOp_in,
  input  logic [DATA_WIDTH-1:0]     PCPlus4_in,
  input  logic [DATA_WIDTH-1:0]     ReadData1_in,
  input  logic [DATA_WIDTH-1:0]     ReadData2_in,
  input  logic [DATA_WIDTH-1:0]     SignExt_in,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_in,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_in,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_in,
  output logic                      RegDst_out,
  output logic                      MemRead_out,
  output logic                      MemToReg_out,
  output logic                      MemWrite_out,
  output logic                      ALUSrc_out,
  output logic                      RegWrite_out,
  output logic [3:0]                ALUOp_out,
  output logic [DATA_WIDTH-1:0]     PCPlus4_out,
  output logic [DATA_WIDTH-1:0]     ReadData1_out,
  output logic [DATA_WIDTH-1:0]     ReadData2_out,
  output logic [DATA_WIDTH-1:0]     SignExt_out,
  output logic [REG_ADDR_WIDTH-1:0] Rs_out,
  output logic [REG_ADDR_WIDTH-1:0] Rt_out,
  output logic [REG_ADDR_WIDTH-1:0] Rd_out,
  output logic                      Valid_out,
  output logic                      HazardStall,
  output logic [CNT_WIDTH-1:0]      BubbleCount
);

  // Control bundle layout: {RegDst, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[3:0]}
  localparam int CTRL_W      = 10;
  localparam int MEMREAD_BIT = 8;
  localparam logic [CTRL_W-1:0]         CTRL_NOP = {CTRL_W{1'b0}};
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CTRL_W-1:0]         ctrl_in_s;
  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0]     read_data1_q, read_data1_d;
  logic [DATA_WIDTH-1:0]     read_data2_q, read_data2_d;
  logic [DATA_WIDTH-1:0]     sign_ext_q, sign_ext_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;
  logic                      hazard_s;
  logic                      bubble_s;

  assign ctrl_in_s = {RegDst_in, MemRead_in, MemToReg_in, MemWrite_in,
                      ALUSrc_in, RegWrite_in, ALUOp_in};

  // A load in EX whose target is read by the ID instruction; $zero is never a dependency.
  assign hazard_s = ~Hold & ctrl_q[MEMREAD_BIT] & valid_q & (rt_q != REG_ZERO) & Valid_in &
                    ((rt_q == Rs_in) | (rt_q == Rt_in));
  assign bubble_s = Flush | hazard_s;

  // Next-state selection: hold, bubble, or normal load.
  always_comb begin
    ctrl_d       = ctrl_q;
    valid_d      = valid_q;
    pc_plus4_d   = pc_plus4_q;
    read_data1_d = read_data1_q;
    read_data2_d = read_data2_q;
    sign_ext_d   = sign_ext_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    if (Hold) begin
      bubble_cnt_d = bubble_cnt_q;
    end else begin
      pc_plus4_d   = PCPlus4_in;
      read_data1_d = ReadData1_in;
      read_data2_d = ReadData2_in;
      sign_ext_d   = SignExt_in;
      rs_d         = Rs_in;
      rt_d         = Rt_in;
      rd_d         = Rd_in;
      if (bubble_s) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
        if (bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
          bubble_cnt_d = bubble_cnt_q;
        end
      end else begin
        valid_d = Valid_in;
        if (Valid_in) begin
          ctrl_d = ctrl_in_s;
        end else begin
          ctrl_d = CTRL_NOP;
        end
      end
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctrl_q       <= CTRL_NOP;
      valid_q      <= 1'b0;
      pc_plus4_q   <= {DATA_WIDTH{1'b0}};
      read_data1_q <= {DATA_WIDTH{1'b0}};
      read_data2_q <= {DATA_WIDTH{1'b0}};
      sign_ext_q   <= {DATA_WIDTH{1'b0}};
      rs_q         <= REG_ZERO;
      rt_q         <= REG_ZERO;
      rd_q         <= REG_ZERO;
      bubble_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      pc_plus4_q   <= pc_plus4_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      sign_ext_q   <= sign_ext_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign {RegDst_out, MemRead_out, MemToReg_out, MemWrite_out,
          ALUSrc_out, RegWrite_out, ALUOp_out} = ctrl_q;
  assign Valid_out     = valid_q;
  assign PCPlus4_out   = pc_plus4_q;
  assign ReadData1_out = read_data1_q;
  assign ReadData2_out = read_data2_q;
  assign SignExt_out   = sign_ext_q;
  assign Rs_out        = rs_q;
  assign Rt_out        = rt_q;
  assign Rd_out        = rd_q;
  assign HazardStall   = hazard_s;
  assign BubbleCount   = bubble_cnt_q;

endmodule
